block_transfer_sequencer: RTL and testbench

//  Multi-cycle micro-op sequencer for ARM LDM/STM block transfers, parametrised in register-file size.

---
 rtl/bt_seq_pkg.sv | 33 +++
 rtl/lowest_set_bit_encoder.sv | 27 ++
 rtl/block_transfer_sequencer.sv | 152 +++++++++++++++
 tb/tb_block_transfer_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_seq_pkg.sv
// Shared definitions for the ARM LDM/STM block-transfer sequencer:
// FSM states, {p,u} addressing modes, stride/id widths and a popcount helper.
package bt_seq_pkg;

    localparam int RD_ID_W            = 5;
    localparam int WORD_BYTES_DEFAULT = 4;
    localparam int MAX_NREG           = 32;
    localparam int CNT_W              = $clog2(MAX_NREG) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Encoded as {p, u}, straight from the instruction bits.
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } addr_mode_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_NREG-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_NREG; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Picks the lowest set bit of a register list: binary index, one-hot mask
// and an empty flag. Pure combinational.
module lowest_set_bit_encoder #(
    parameter  int NREG  = 16,
    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic [NREG-1:0]  list,
    output logic [IDX_W-1:0] index,
    output logic [NREG-1:0]  onehot,
    output logic             empty
);

    // NOTE: default assignment first so no path through the loop leaves index unassigned (no latch).
    always_comb begin
        index = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = list & (~list + NREG'(1));
    assign empty  = ~|list;

endmodule

// File: rtl/block_transfer_sequencer.sv
// Expands one decoded LDM/STM command into single-register load/store
// micro-ops in ascending register order, with base writeback on the last beat.
module block_transfer_sequencer
    import bt_seq_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NREG       = 16,
    parameter int ID_W       = RD_ID_W,
    parameter int WORD_BYTES = WORD_BYTES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [NREG-1:0]   cmd_list,
    input  logic [DATA_W-1:0] cmd_base,
    input  logic [3:0]        cmd_rn,
    input  logic              cmd_p,
    input  logic              cmd_u,
    input  logic              cmd_w,
    input  logic              cmd_l,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [DATA_W-1:0] uop_addr,
    output logic [ID_W-1:0]   uop_reg_id,
    output logic              uop_load,
    output logic              uop_is_pc,
    output logic              uop_last,
    output logic              wb_en,
    output logic [DATA_W-1:0] wb_value,
    input  logic              flush,
    output logic              done
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [DATA_W-1:0] STRIDE = DATA_W'(WORD_BYTES);

    state_e            state;
    logic [NREG-1:0]   remaining;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wb_value_q;
    logic              load_q;
    logic              wb_ok_q;

    logic [IDX_W-1:0]  lsb_idx;
    logic [NREG-1:0]   lsb_onehot;
    logic              lsb_empty;
    logic              last_beat;

    logic [DATA_W-1:0] span;
    logic [DATA_W-1:0] start_addr;
    logic [DATA_W-1:0] end_base;
    logic              rn_hit;

    lowest_set_bit_encoder #(.NREG(NREG)) u_lsb (
        .list   (remaining),
        .index  (lsb_idx),
        .onehot (lsb_onehot),
        .empty  (lsb_empty)
    );

    // Start address and final base, evaluated on the accept cycle only.
    always_comb begin
        span       = DATA_W'(popcount(MAX_NREG'(cmd_list))) * STRIDE;
        start_addr = cmd_base;
        case (addr_mode_e'({cmd_p, cmd_u}))
            MODE_IA: start_addr = cmd_base;
            MODE_IB: start_addr = cmd_base + STRIDE;
            MODE_DA: start_addr = cmd_base - span + STRIDE;
            MODE_DB: start_addr = cmd_base - span;
            default: start_addr = cmd_base;
        endcase
        end_base = cmd_u ? (cmd_base + span) : (cmd_base - span);
        rn_hit   = |(cmd_list & (NREG'(1) << cmd_rn));
    end

    assign last_beat  = !lsb_empty && ((remaining & ~lsb_onehot) == '0);
    assign uop_addr   = addr_q;
    assign uop_reg_id = ID_W'(lsb_idx);
    assign uop_load   = load_q;
    assign uop_is_pc  = uop_valid && load_q && (uop_reg_id == ID_W'(15));
    assign uop_last   = uop_valid && last_beat;
    assign wb_en      = uop_last && wb_ok_q;
    assign wb_value   = wb_value_q;

    // NOTE: sequential state uses non-blocking assignments only; datapath registers
    // are reset as well so every output has a defined value straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            uop_valid  <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            addr_q     <= '0;
            wb_value_q <= '0;
            load_q     <= 1'b0;
            wb_ok_q    <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            uop_valid <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        remaining  <= cmd_list;
                        addr_q     <= start_addr;
                        wb_value_q <= end_base;
                        load_q     <= cmd_l;
                        // A loaded base register overrides the writeback.
                        wb_ok_q    <= cmd_w && !(cmd_l && rn_hit);
                        cmd_ready  <= 1'b0;
                        if (cmd_list == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            uop_valid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (uop_ready) begin
                        remaining <= remaining & ~lsb_onehot;
                        addr_q    <= addr_q + STRIDE;
                        if (last_beat) begin
                            state     <= ST_DONE;
                            uop_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    uop_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed bench for block_transfer_sequencer: stimulus pushes hand-computed
// beats and done pulses into a queue; a negedge monitor pops and compares.
module tb_block_transfer_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_list;
    logic [31:0] cmd_base;
    logic [3:0]  cmd_rn;
    logic        cmd_p, cmd_u, cmd_w, cmd_l;
    logic        uop_valid;
    logic        uop_ready;
    logic [31:0] uop_addr;
    logic [4:0]  uop_reg_id;
    logic        uop_load, uop_is_pc, uop_last;
    logic        wb_en;
    logic [31:0] wb_value;
    logic        flush;
    logic        done;

    block_transfer_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_list   (cmd_list),
        .cmd_base   (cmd_base),
        .cmd_rn     (cmd_rn),
        .cmd_p      (cmd_p),
        .cmd_u      (cmd_u),
        .cmd_w      (cmd_w),
        .cmd_l      (cmd_l),
        .uop_valid  (uop_valid),
        .uop_ready  (uop_ready),
        .uop_addr   (uop_addr),
        .uop_reg_id (uop_reg_id),
        .uop_load   (uop_load),
        .uop_is_pc  (uop_is_pc),
        .uop_last   (uop_last),
        .wb_en      (wb_en),
        .wb_value   (wb_value),
        .flush      (flush),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic [31:0] addr;
        logic [4:0]  id;
        logic        load;
        logic        is_pc;
        logic        last;
        logic        wb_en;
        logic [31:0] wb_value;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_uop(input logic [31:0] addr, input logic [4:0] id, input logic load,
                            input logic is_pc, input logic last, input logic wbe,
                            input logic [31:0] wbv);
        exp_t e;
        e = '{is_done: 1'b0, addr: addr, id: id, load: load, is_pc: is_pc,
              last: last, wb_en: wbe, wb_value: (last ? wbv : 32'h0)};
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e = '0;
        e.is_done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every presented beat against the queue head, pops on handshake.
    always @(negedge clk) begin
        exp_t act;
        exp_t head;
        if (rst_n && !flush) begin
            if (uop_valid) begin
                act = '{is_done: 1'b0, addr: uop_addr, id: uop_reg_id, load: uop_load,
                        is_pc: uop_is_pc, last: uop_last, wb_en: wb_en,
                        wb_value: (uop_last ? wb_value : 32'h0)};
                if (exp_q.size() == 0) begin
                    check("uop_expected", 128'(exp_q.size() > 0), 128'(1));
                end else begin
                    head = exp_q[0];
                    check("uop", 128'(act), 128'(head));
                    if (uop_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                act = '0;
                act.is_done = done;
                if (exp_q.size() == 0) begin
                    check("done_expected", 128'(exp_q.size() > 0), 128'(1));
                end else begin
                    head = exp_q[0];
                    check("done", 128'(act), 128'(head));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] list, input logic [31:0] base, input logic [3:0] rn,
                            input logic p, input logic u, input logic w, input logic l);
        int waited;
        cmd_list  = list;
        cmd_base  = base;
        cmd_rn    = rn;
        cmd_p     = p;
        cmd_u     = u;
        cmd_w     = w;
        cmd_l     = l;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("cmd_ready_timeout", 128'(cmd_ready), 128'(1));
        tick();
        // Scramble the command bus after acceptance; it must have no effect.
        cmd_valid = 1'b0;
        cmd_list  = 16'hFFFF;
        cmd_base  = 32'hDEAD_BEEF;
        cmd_rn    = ~rn;
        cmd_p     = ~p;
        cmd_u     = ~u;
        cmd_w     = ~w;
        cmd_l     = ~l;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && c < 100) begin
            tick();
            c++;
        end
        check(name, 128'({cmd_ready, exp_q.size() == 0}), 128'(2'b11));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_done;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_list  = '0;
        cmd_base  = '0;
        cmd_rn    = '0;
        {cmd_p, cmd_u, cmd_w, cmd_l} = 4'b0;
        uop_ready = 1'b1;
        flush     = 1'b0;

        repeat (3) tick();
        check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        check("rst_uop_valid", 128'(uop_valid), 128'(0));
        check("rst_done",      128'(done),      128'(0));
        check("rst_wb_en",     128'(wb_en),     128'(0));
        check("rst_misc",      128'({uop_addr, uop_reg_id, uop_load, uop_is_pc, uop_last, wb_value}), 128'(0));
        rst_n = 1'b1;
        tick();

        // 1. IA load of r0..r3, ready held: n beats then done on cycle n+1.
        push_uop(32'h1000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h1004, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h1008, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h100C, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1010);
        push_done();
        send_cmd(16'h000F, 32'h1000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s1_first_valid", 128'(uop_valid), 128'(1));
        first_done = 0;
        for (int c = 1; c <= 8; c++) begin
            if (done && first_done == 0) first_done = c;
            tick();
        end
        check("s1_done_latency", 128'(first_done), 128'(5));
        wait_drain("s1_drain");

        // 2. DB store with writeback, r15 as a store is not a PC redirect.
        push_uop(32'h1FF8, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h1FFC, 5'd15, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1FF8);
        push_done();
        send_cmd(16'h8001, 32'h2000, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_drain("s2_drain");

        // 3. IB load, base r2 in list suppresses writeback; ready 1-0-0-1.
        push_uop(32'h4004, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h4008, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4008);
        push_done();
        send_cmd(16'h0006, 32'h4000, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        uop_ready = 1'b0;
        tick();
        tick();
        uop_ready = 1'b1;
        wait_drain("s3_drain");

        // PC load with writeback of an unrelated base.
        push_uop(32'h0100, 5'd15, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0104);
        push_done();
        send_cmd(16'h8000, 32'h0100, 4'd13, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_drain("pc_drain");

        // 4. Empty list: done on the cycle after acceptance, no beats.
        push_done();
        send_cmd(16'h0000, 32'h6000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("s4_done",      128'(done),      128'(1));
        check("s4_busy",      128'(cmd_ready), 128'(0));
        check("s4_no_uop",    128'(uop_valid), 128'(0));
        tick();
        check("s4_ready_back", 128'({cmd_ready, done}), 128'(2'b10));
        wait_drain("s4_drain");

        // 5. DA and DB with wrap-around below zero.
        push_uop(32'h0000_0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h0000_0004, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        push_done();
        send_cmd(16'h0003, 32'h0000_0004, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain("s5_da_drain");
        push_uop(32'hFFFF_FFFC, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h0000_0000, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        push_done();
        send_cmd(16'h0003, 32'h0000_0004, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain("s5_db_drain");

        // 6a. Flush on beat 2 together with ready: beat dropped, no done.
        push_uop(32'h3000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        send_cmd(16'h000F, 32'h3000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("s6a_after_flush", 128'({uop_valid, done, cmd_ready}), 128'(3'b001));
        repeat (3) tick();
        check("s6a_queue", 128'(exp_q.size()), 128'(0));

        // 6b. Async reset mid-command clears outputs immediately.
        push_uop(32'h5000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h5004, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        send_cmd(16'h000F, 32'h5000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        uop_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("s6b_rst_ctrl", 128'({cmd_ready, uop_valid, done, wb_en, uop_last}), 128'(5'b10000));
        check("s6b_rst_addr", 128'(uop_addr), 128'(0));
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        uop_ready = 1'b1;
        tick();
        check("s6b_no_uop", 128'({uop_valid, cmd_ready}), 128'(2'b01));

        // Recovery: IA store with writeback after the reset.
        push_uop(32'h7000, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        push_uop(32'h7004, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7008);
        push_done();
        send_cmd(16'h0030, 32'h7000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain("recovery_drain");

        check("queue_empty_end", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
